// File: rtl/joycon_pkg.sv
// -----------------------------------------------------------------------------
// joycon_pkg
// Shared definitions for the NES pad poller:
//   - BTN_* : bit index of each button in the 8-bit button vector
//   - state_t : poller FSM state encoding
//   - raw_to_buttons : converts an active-low wire frame to active-high buttons
// -----------------------------------------------------------------------------
package joycon_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_CLK_LO = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    // The pad pulls a line low for a pressed button.
    function automatic logic [7:0] raw_to_buttons(input logic [7:0] raw);
        return ~raw;
    endfunction

endpackage

// File: rtl/joycon_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous reset, active-low (flops reset to 1 = line idle high)
//   i_d     : asynchronous input
//   o_q     : synchronised output
// -----------------------------------------------------------------------------
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/joycon_poller.sv
// -----------------------------------------------------------------------------
// joycon_poller
// Periodically reads an NES pad (CD4021 parallel-in/serial-out register):
// strobes pad_latch, then clocks out 8 active-low bits on pad_clk while sampling
// the synchronised pad_data, and commits an active-high button vector.
// With DEBOUNCE=1 a frame is committed only if it equals the previous frame.
// Ports:
//   clk           : system clock
//   rst           : asynchronous reset, active-low
//   poll_en       : 1 = polling enabled
//   pad_data      : serial data from the pad (async, active-low)
//   pad_latch     : parallel-load strobe to the pad
//   pad_clk       : shift clock to the pad
//   buttons[7:0]  : committed button state, 1 = pressed (A,B,Sel,Start,U,D,L,R)
//   buttons_valid : one-cycle pulse when buttons is (re)committed
//   busy          : high while a frame is in progress
// -----------------------------------------------------------------------------
module joycon_poller
    import joycon_pkg::*;
#(
    parameter int POLL_DIV     = 200000,
    parameter int LATCH_CYCLES = 12,
    parameter int HALF_PERIOD  = 6,
    parameter int DEBOUNCE     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       poll_en,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       busy
);

    localparam int PC_W   = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int PH_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int PH_W   = $clog2(PH_MAX) + 1;

    localparam logic [PC_W-1:0] POLL_LAST  = PC_W'(POLL_DIV - 1);
    localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_PERIOD - 1);

    logic             w_sync_data;
    logic             w_phase_done;

    state_t           r_state;
    logic [PC_W-1:0]  r_poll_cnt;
    logic [PH_W-1:0]  r_phase;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;      // current frame, raw active-low
    logic [7:0]       r_prev;       // previous frame, raw active-low
    logic [7:0]       r_buttons;
    logic             r_valid;
    logic             r_latch;
    logic             r_clk;
    logic             r_busy;

    sync2 u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (pad_data),
        .o_q     (w_sync_data)
    );

    // One phase counter serves every timed state; only LATCH has its own length.
    assign w_phase_done = (r_state == ST_LATCH) ? (r_phase == LATCH_LAST)
                                                : (r_phase == HALF_LAST);

    // Poll period counter: cleared whenever polling is off so that re-enabling
    // always waits a full period before the first frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_poll_cnt <= '0;
        end else if (!poll_en) begin
            r_poll_cnt <= '0;
        end else if (r_poll_cnt == POLL_LAST) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
        end
    end

    // Frame FSM. Outputs are updated on the same edge as the state they belong
    // to, so pad_latch/pad_clk/busy track the state without combinational decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'hFF;
            r_prev    <= 8'hFF;
            r_buttons <= 8'h00;
            r_valid   <= 1'b0;
            r_latch   <= 1'b0;
            r_clk     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_phase <= r_phase + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_phase <= '0;
                    // poll_en is only consulted here: a running frame always finishes.
                    if (poll_en && (r_poll_cnt == POLL_LAST)) begin
                        r_state <= ST_LATCH;
                        r_latch <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (w_phase_done) begin
                        r_state <= ST_SETTLE;
                        r_latch <= 1'b0;
                        r_phase <= '0;
                    end
                end
                ST_SETTLE: begin
                    // The 4021 presents bit0 right after the load, before any clock.
                    if (w_phase_done) begin
                        r_shift[0] <= w_sync_data;
                        r_bit_cnt  <= 3'd1;
                        r_state    <= ST_CLK_HI;
                        r_clk      <= 1'b1;
                        r_phase    <= '0;
                    end
                end
                ST_CLK_HI: begin
                    if (w_phase_done) begin
                        r_state <= ST_CLK_LO;
                        r_clk   <= 1'b0;
                        r_phase <= '0;
                    end
                end
                ST_CLK_LO: begin
                    // Sampling at the end of the low half leaves a full half-period
                    // for the shifted bit to pass the synchroniser.
                    if (w_phase_done) begin
                        r_shift[r_bit_cnt] <= w_sync_data;
                        r_phase            <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_state   <= ST_CLK_HI;
                            r_clk     <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if ((DEBOUNCE == 0) || (r_shift == r_prev)) begin
                        r_buttons <= raw_to_buttons(r_shift);
                        r_valid   <= 1'b1;
                    end
                    r_prev    <= r_shift;
                    r_bit_cnt <= 3'd0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_latch <= 1'b0;
                    r_clk   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pad_latch     = r_latch;
    assign pad_clk       = r_clk;
    assign buttons       = r_buttons;
    assign buttons_valid = r_valid;
    assign busy          = r_busy;

endmodule

// File: tb/tb_joycon_poller.sv
// -----------------------------------------------------------------------------
// tb_joycon_poller
// Two poller instances (DEBOUNCE=0 and DEBOUNCE=1, POLL_DIV=200), each wired to
// a behavioural CD4021 pad. Expected commits are queued by the stimulus and
// popped by per-instance monitors whenever buttons_valid pulses.
// -----------------------------------------------------------------------------
module tb_joycon_poller;
    import joycon_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       poll_en0 = 1'b0, poll_en1 = 1'b0;
    logic       pad_data0, pad_data1;
    logic       pad_latch0, pad_latch1;
    logic       pad_clk0, pad_clk1;
    logic [7:0] buttons0, buttons1;
    logic       buttons_valid0, buttons_valid1;
    logic       busy0, busy1;

    logic [7:0] btn0 = 8'h00, btn1 = 8'h00;   // pressed buttons, active-high
    logic [7:0] sr0 = 8'hFF, sr1 = 8'hFF;     // 4021 shift registers

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid0 = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    // frame statistics for instance 1
    int frames_done1 = 0;
    int s_latch, s_pulses, s_hi_min, s_hi_max, s_busy;
    bit s_overlap;

    always #5 clk = ~clk;

    joycon_poller #(.POLL_DIV(200), .LATCH_CYCLES(12), .HALF_PERIOD(6), .DEBOUNCE(0)) u_dut0 (
        .clk(clk), .rst(rst), .poll_en(poll_en0), .pad_data(pad_data0),
        .pad_latch(pad_latch0), .pad_clk(pad_clk0), .buttons(buttons0),
        .buttons_valid(buttons_valid0), .busy(busy0)
    );

    joycon_poller #(.POLL_DIV(200), .LATCH_CYCLES(12), .HALF_PERIOD(6), .DEBOUNCE(1)) u_dut1 (
        .clk(clk), .rst(rst), .poll_en(poll_en1), .pad_data(pad_data1),
        .pad_latch(pad_latch1), .pad_clk(pad_clk1), .buttons(buttons1),
        .buttons_valid(buttons_valid1), .busy(busy1)
    );

    // CD4021 models: load while latch rises, shift toward bit0 on clk rise, serial-in pulled up.
    initial forever begin
        @(posedge pad_latch0 or posedge pad_clk0);
        if (pad_latch0) sr0 = ~btn0;
        else            sr0 = {1'b1, sr0[7:1]};
    end
    initial forever begin
        @(posedge pad_latch1 or posedge pad_clk1);
        if (pad_latch1) sr1 = ~btn1;
        else            sr1 = {1'b1, sr1[7:1]};
    end
    assign pad_data0 = sr0[0];
    assign pad_data1 = sr1[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors
    initial forever begin
        @(negedge clk);
        if (buttons_valid0 === 1'b1) begin
            n_valid0++;
            if (exp0.size() == 0) check("dut0_unexpected_valid", {24'h0, buttons0}, 32'hDEAD);
            else                  check("dut0_commit", {24'h0, buttons0}, {24'h0, exp0.pop_front()});
        end
    end
    initial forever begin
        @(negedge clk);
        if (buttons_valid1 === 1'b1) begin
            if (exp1.size() == 0) check("dut1_unexpected_valid", {24'h0, buttons1}, 32'hDEAD);
            else                  check("dut1_commit", {24'h0, buttons1}, {24'h0, exp1.pop_front()});
        end
    end

    // Per-frame pulse/length statistics for instance 1
    initial begin
        int f_latch, f_pulses, f_hi_min, f_hi_max, f_hi_cur, f_busy;
        bit f_overlap;
        logic p_clk, p_busy;
        p_clk = 1'b0; p_busy = 1'b0;
        f_latch = 0; f_pulses = 0; f_hi_min = 0; f_hi_max = 0; f_hi_cur = 0; f_busy = 0; f_overlap = 0;
        forever begin
            @(negedge clk);
            if (busy1 && !p_busy) begin
                f_latch = 0; f_pulses = 0; f_hi_min = 1000; f_hi_max = 0;
                f_hi_cur = 0; f_busy = 0; f_overlap = 0;
            end
            if (busy1) f_busy++;
            if (pad_latch1) f_latch++;
            if (pad_latch1 && pad_clk1) f_overlap = 1;
            if (pad_clk1) begin
                if (!p_clk) f_pulses++;
                f_hi_cur++;
            end else if (p_clk) begin
                if (f_hi_cur < f_hi_min) f_hi_min = f_hi_cur;
                if (f_hi_cur > f_hi_max) f_hi_max = f_hi_cur;
                f_hi_cur = 0;
            end
            if (!busy1 && p_busy) begin
                s_latch = f_latch; s_pulses = f_pulses; s_hi_min = f_hi_min;
                s_hi_max = f_hi_max; s_busy = f_busy; s_overlap = f_overlap;
                frames_done1++;
            end
            p_clk  = pad_clk1;
            p_busy = busy1;
        end
    end

    task automatic wait_frames1(input int n, input string name);
        int target = frames_done1 + n;
        for (int k = 0; k < n * 400 && frames_done1 < target; k++) @(negedge clk);
        check(name, (frames_done1 >= target) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_clk_edges1(input int n, input bit rising, input string name);
        int   seen = 0;
        logic prev = pad_clk1;
        for (int k = 0; k < 600 && seen < n; k++) begin
            @(negedge clk);
            if (rising ? (pad_clk1 && !prev) : (!pad_clk1 && prev)) seen++;
            prev = pad_clk1;
        end
        check(name, seen, n);
    endtask

    initial begin
        int cyc;
        int lat_cnt;
        bit seen_busy;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_buttons0", {24'h0, buttons0}, 32'h00);
        check("rst_valid0", {31'h0, buttons_valid0}, 32'h0);
        check("rst_latch0", {31'h0, pad_latch0}, 32'h0);
        check("rst_clk0", {31'h0, pad_clk0}, 32'h0);
        check("rst_busy0", {31'h0, busy0}, 32'h0);
        check("rst_buttons1", {24'h0, buttons1}, 32'h00);
        check("rst_busy1", {31'h0, busy1}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1: DEBOUNCE=0, A+Start commits after the first frame
        btn0 = (8'(1) << BTN_A) | (8'(1) << BTN_START);
        exp0.push_back(8'h09);
        poll_en0 = 1'b1;
        seen_busy = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (busy0) seen_busy = 1;
            if (seen_busy && !busy0) break;
        end
        check("t1_frame_done", {31'h0, (seen_busy && !busy0)}, 32'h1);
        poll_en0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t1_buttons", {24'h0, buttons0}, 32'h09);

        // Test 2/3: DEBOUNCE=1, Up on two frames -> commit on frame 2
        btn1 = 8'(1) << BTN_UP;
        poll_en1 = 1'b1;
        wait_frames1(1, "t2_frame1");
        check("t2_no_commit_f1", {24'h0, buttons1}, 32'h00);
        check("t3_latch_cycles", s_latch, 12);
        check("t3_clk_pulses", s_pulses, 7);
        check("t3_clk_hi_min", s_hi_min, 6);
        check("t3_clk_hi_max", s_hi_max, 6);
        check("t3_overlap", {31'h0, s_overlap}, 32'h0);
        check("t3_busy_cycles", s_busy, 103);
        exp1.push_back(8'h10);
        wait_frames1(1, "t2_frame2");
        check("t2_commit_f2", {24'h0, buttons1}, 32'h10);
        btn1 = 8'(1) << BTN_DOWN;
        wait_frames1(1, "t2_frame3");
        check("t2_glitch_held", {24'h0, buttons1}, 32'h10);
        btn1 = 8'(1) << BTN_UP;
        wait_frames1(1, "t2_frame4");
        check("t2_after_glitch", {24'h0, buttons1}, 32'h10);

        // Test 4: drop poll_en at the third pad_clk high phase
        exp1.push_back(8'h10);
        wait_clk_edges1(3, 1'b1, "t4_third_clk");
        poll_en1 = 1'b0;
        wait_frames1(1, "t4_frame_completes");
        check("t4_buttons", {24'h0, buttons1}, 32'h10);
        lat_cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (pad_latch1 || busy1) lat_cnt++;
        end
        check("t4_no_latch_disabled", lat_cnt, 0);
        poll_en1 = 1'b1;
        cyc = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            cyc++;
            if (pad_latch1) break;
        end
        check("t4_reenable_latency", cyc, 200);

        // Test 5: reset during the CLK_LO phase after the fifth pad_clk pulse
        btn1 = 8'(1) << BTN_RIGHT;
        wait_clk_edges1(5, 1'b0, "t5_fifth_fall");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_buttons", {24'h0, buttons1}, 32'h00);
        check("t5_valid", {31'h0, buttons_valid1}, 32'h0);
        check("t5_latch", {31'h0, pad_latch1}, 32'h0);
        check("t5_clk", {31'h0, pad_clk1}, 32'h0);
        check("t5_busy", {31'h0, busy1}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        check("t5_buttons_idle", {24'h0, buttons1}, 32'h00);

        // Test 6: all buttons held; one priming frame, then three agreeing frames
        btn1 = 8'hFF;
        wait_frames1(1, "t6_prime");
        check("t6_prime_no_commit", {24'h0, buttons1}, 32'h00);
        for (int f = 0; f < 3; f++) begin
            exp1.push_back(8'hFF);
            wait_frames1(1, "t6_frame");
            check("t6_buttons", {24'h0, buttons1}, 32'hFF);
        end

        repeat (5) @(negedge clk);
        check("dut0_valid_pulses", n_valid0, 1);
        check("dut0_queue_empty", exp0.size(), 0);
        check("dut1_queue_empty", exp1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
